dmem_access_ctrl: RTL and testbench

//  Memory-stage data-memory access controller, directly upstream of the load masker.

---
 rtl/dmem_access_ctrl_if.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Memory-side request/acknowledge port of the data-memory access controller.
// The controller drives the request side (master); the memory answers with
// mem_ack and, for loads, the raw read word (slave).
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller.
// Takes one load/store per instruction, issues a registered req/ack access
// with big-endian byte enables, stalls the pipeline until the access ends,
// and hands the raw read word, byte offset and opcode to the load masker.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic [5:0]             opcode,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   stall,
    dmem_access_ctrl_if.master     mem,
    output logic [31:0]            rdata_out,
    output logic [1:0]             offset_out,
    output logic [5:0]             opcode_out,
    output logic                   rdata_valid,
    output logic                   misalign_err,
    output logic                   bus_err
);

    // Opcode encodings shared with the decoder.
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Wait counter sized to reach TIMEOUT_CYC-1; unused when timeout is disabled.
    localparam int             CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic           TO_EN    = (TIMEOUT_CYC != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
            default:             is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_LH, OP_LHU, OP_SH: is_misaligned = off[0];
            OP_LW, OP_SW:         is_misaligned = (off != 2'b00);
            default:              is_misaligned = 1'b0;
        endcase
    endfunction

    // Big-endian lanes: offset 00 addresses bits 31:24, i.e. we[3].
    function automatic logic [3:0] lane_we(input logic [5:0] op, input logic [1:0] off);
        case (op)
            OP_SB:   lane_we = 4'b1000 >> off;
            OP_SH:   lane_we = off[1] ? 4'b0011 : 4'b1100;
            OP_SW:   lane_we = 4'b1111;
            default: lane_we = 4'b0000;
        endcase
    endfunction

    // Replicate narrow store data into every lane so the enables pick the target.
    function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] wd);
        case (op)
            OP_SB:   lane_wdata = {4{wd[7:0]}};
            OP_SH:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             mem_op_s;
    logic             stall_s;
    logic             misalign_s;
    logic             issue_s;
    logic             ack_s;
    logic             timeout_s;
    logic             timeout_hit_s;

    logic             mem_req_r;
    logic [3:0]       mem_we_r;
    logic [29:0]      mem_addr_r;
    logic [31:0]      mem_wdata_r;
    logic [1:0]       off_lat_r;
    logic [5:0]       op_lat_r;
    logic [31:0]      rdata_out_r;
    logic [1:0]       offset_out_r;
    logic [5:0]       opcode_out_r;
    logic             rdata_valid_r;
    logic             bus_err_r;

    assign mem_op_s      = req_valid && is_mem_op(opcode);
    assign timeout_hit_s = TO_EN && (cnt_r == CNT_LAST);

    // Next-state and per-cycle control decode for IDLE/WAIT/RESP.
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        misalign_s  = 1'b0;
        issue_s     = 1'b0;
        ack_s       = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    if (is_misaligned(opcode, addr[1:0])) begin
                        misalign_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        stall_s     = 1'b1;
                        issue_s     = 1'b1;
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (mem.mem_ack) begin
                    ack_s       = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (timeout_hit_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                // The same instruction is still presented here; never resample it.
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and wait-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (issue_s) begin
                cnt_r <= '0;
            end else if (state_r == ST_WAIT && !ack_s) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Memory port registers: loaded on issue, held through WAIT, dropped on ack or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 4'b0000;
            mem_addr_r  <= 30'd0;
            mem_wdata_r <= 32'd0;
            off_lat_r   <= 2'b00;
            op_lat_r    <= 6'd0;
        end else if (issue_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= lane_we(opcode, addr[1:0]);
            mem_addr_r  <= addr[31:2];
            mem_wdata_r <= lane_wdata(opcode, wdata);
            off_lat_r   <= addr[1:0];
            op_lat_r    <= opcode;
        end else if (ack_s || timeout_s) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 4'b0000;
        end else begin
            mem_req_r   <= mem_req_r;
            mem_we_r    <= mem_we_r;
        end
    end

    // Response registers for the load masker plus the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_out_r   <= 32'd0;
            offset_out_r  <= 2'b00;
            opcode_out_r  <= 6'd0;
            rdata_valid_r <= 1'b0;
            bus_err_r     <= 1'b0;
        end else begin
            rdata_valid_r <= ack_s && is_load(op_lat_r);
            bus_err_r     <= timeout_s;
            if (ack_s) begin
                offset_out_r <= off_lat_r;
                opcode_out_r <= op_lat_r;
                if (is_load(op_lat_r)) begin
                    rdata_out_r <= mem.mem_rdata;
                end else begin
                    rdata_out_r <= rdata_out_r;
                end
            end else begin
                offset_out_r <= offset_out_r;
                opcode_out_r <= opcode_out_r;
                rdata_out_r  <= rdata_out_r;
            end
        end
    end

    assign stall         = stall_s;
    assign misalign_err  = misalign_s;
    assign mem.mem_req   = mem_req_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign rdata_out     = rdata_out_r;
    assign offset_out    = offset_out_r;
    assign opcode_out    = opcode_out_r;
    assign rdata_valid   = rdata_valid_r;
    assign bus_err       = bus_err_r;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl (TIMEOUT_CYC = 4).
module tb_dmem_access_ctrl;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef struct {
        logic [5:0]  opc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;
        logic        mis;
        logic [3:0]  we;
        logic [29:0] maddr;
        logic [31:0] mwdata;
        logic        ld;
        logic [1:0]  off;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata_out;
    logic [1:0]  offset_out;
    logic [5:0]  opcode_out;
    logic        rdata_valid;
    logic        misalign_err;
    logic        bus_err;

    int          n_cmp;
    int          n_err;
    int          cur_vec;
    logic [31:0] last_rdata;
    vec_t        vecs[16];

    dmem_access_ctrl_if mif();

    dmem_access_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .opcode       (opcode),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .mem          (mif),
        .rdata_out    (rdata_out),
        .offset_out   (offset_out),
        .opcode_out   (opcode_out),
        .rdata_valid  (rdata_valid),
        .misalign_err (misalign_err),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got 0x%08h, want 0x%08h", name, cur_vec, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int ack, input logic mis,
                                input logic [3:0] we, input logic [29:0] ma, input logic [31:0] mwd,
                                input logic ld, input logic [1:0] off);
        vec_t v;
        v.opc = opc; v.addr = a; v.wdata = wd; v.rdata = rd; v.ack_at = ack; v.mis = mis;
        v.we = we; v.maddr = ma; v.mwdata = mwd; v.ld = ld; v.off = off;
        return v;
    endfunction

    // Entered just after a rising edge with the controller in IDLE.
    task automatic run_vec(input vec_t v);
        int stall_cnt;
        req_valid     = 1'b1;
        opcode        = v.opc;
        addr          = v.addr;
        wdata         = v.wdata;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = v.rdata;
        @(negedge clk);
        if (v.mis) begin
            check("misalign_err", misalign_err, 1'b1);
            check("mis_stall", stall, 1'b0);
            check("mis_req", mif.mem_req, 1'b0);
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("mis_req_after", mif.mem_req, 1'b0);
            check("mis_err_clear", misalign_err, 1'b0);
            @(posedge clk); #1;
        end else begin
            check("issue_stall", stall, 1'b1);
            check("issue_misalign", misalign_err, 1'b0);
            check("issue_req_not_yet", mif.mem_req, 1'b0);
            stall_cnt = 1;
            @(posedge clk); #1;
            for (int k = 1; k <= v.ack_at; k++) begin
                mif.mem_ack = (k == v.ack_at);
                @(negedge clk);
                if (stall) stall_cnt++;
                check("wait_req", mif.mem_req, 1'b1);
                check("wait_we", mif.mem_we, v.we);
                check("wait_addr", mif.mem_addr, v.maddr);
                if (!v.ld) check("wait_wdata", mif.mem_wdata, v.mwdata);
                @(posedge clk); #1;
            end
            mif.mem_ack   = 1'b0;
            mif.mem_rdata = 32'h0BAD_0BAD;
            @(negedge clk);
            check("resp_stall", stall, 1'b0);
            check("resp_req", mif.mem_req, 1'b0);
            check("resp_we", mif.mem_we, 4'b0000);
            check("resp_rdata_valid", rdata_valid, v.ld);
            check("stall_cycles", stall_cnt, v.ack_at + 1);
            if (v.ld) begin
                check("rdata_out", rdata_out, v.rdata);
                check("offset_out", offset_out, v.off);
                check("opcode_out", opcode_out, v.opc);
                last_rdata = v.rdata;
            end else begin
                check("rdata_hold", rdata_out, last_rdata);
            end
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            check("post_rdata_valid", rdata_valid, 1'b0);
            check("no_reissue_req", mif.mem_req, 1'b0);
            check("post_stall", stall, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    // Runaway guard: the directed sequences are short.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0; n_err = 0; cur_vec = -1; last_rdata = 32'd0;
        rst_n = 1'b0; req_valid = 1'b0; opcode = 6'd0; addr = 32'd0; wdata = 32'd0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;

        //           opc  addr          wdata         rdata         ack mis we       maddr          mwdata        ld    off
        vecs[0]  = mk(SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        3, 1'b0, 4'b1111, 30'h40,        32'hDEAD_BEEF, 1'b0, 2'd0);
        vecs[1]  = mk(SB,  32'h0000_0103, 32'h0000_00AB, 32'h0,        1, 1'b0, 4'b0001, 30'h40,        32'hABAB_ABAB, 1'b0, 2'd3);
        vecs[2]  = mk(SH,  32'h0000_0102, 32'h0000_1234, 32'h0,        2, 1'b0, 4'b0011, 30'h40,        32'h1234_1234, 1'b0, 2'd2);
        vecs[3]  = mk(SB,  32'h0000_0100, 32'h0000_005A, 32'h0,        1, 1'b0, 4'b1000, 30'h40,        32'h5A5A_5A5A, 1'b0, 2'd0);
        vecs[4]  = mk(SH,  32'h0000_0100, 32'hCAFE_BEEF, 32'h0,        1, 1'b0, 4'b1100, 30'h40,        32'hBEEF_BEEF, 1'b0, 2'd0);
        vecs[5]  = mk(SB,  32'h0000_0102, 32'h0000_0077, 32'h0,        2, 1'b0, 4'b0010, 30'h40,        32'h7777_7777, 1'b0, 2'd2);
        vecs[6]  = mk(LB,  32'h0000_0201, 32'h0,         32'h1122_3344, 1, 1'b0, 4'b0000, 30'h80,        32'h0,         1'b1, 2'd1);
        vecs[7]  = mk(LHU, 32'h0000_02FE, 32'h0,         32'hA5A5_0F0F, 2, 1'b0, 4'b0000, 30'hBF,        32'h0,         1'b1, 2'd2);
        vecs[8]  = mk(LW,  32'h0000_1000, 32'h0,         32'hCAFE_F00D, 3, 1'b0, 4'b0000, 30'h400,       32'h0,         1'b1, 2'd0);
        vecs[9]  = mk(SW,  32'h0000_0204, 32'h0102_0304, 32'h0,        2, 1'b0, 4'b1111, 30'h81,        32'h0102_0304, 1'b0, 2'd0);
        vecs[10] = mk(LBU, 32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1, 1'b0, 4'b0000, 30'h3FFF_FFFF, 32'h0,         1'b1, 2'd3);
        vecs[11] = mk(LH,  32'h0000_0101, 32'h0,         32'h0,        1, 1'b1, 4'b0000, 30'h0,         32'h0,         1'b1, 2'd1);
        vecs[12] = mk(LW,  32'h0000_0102, 32'h0,         32'h0,        1, 1'b1, 4'b0000, 30'h0,         32'h0,         1'b1, 2'd2);
        vecs[13] = mk(SW,  32'h0000_0203, 32'h1,         32'h0,        1, 1'b1, 4'b0000, 30'h0,         32'h0,         1'b0, 2'd3);
        vecs[14] = mk(SH,  32'h0000_0201, 32'h1,         32'h0,        1, 1'b1, 4'b0000, 30'h0,         32'h0,         1'b0, 2'd1);
        vecs[15] = mk(LHU, 32'h0000_03FF, 32'h0,         32'h0,        1, 1'b1, 4'b0000, 30'h0,         32'h0,         1'b1, 2'd3);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_req", mif.mem_req, 1'b0);
        check("rst_we", mif.mem_we, 4'b0000);
        check("rst_addr", mif.mem_addr, 30'd0);
        check("rst_wdata", mif.mem_wdata, 32'd0);
        check("rst_rdata_out", rdata_out, 32'd0);
        check("rst_opcode_out", opcode_out, 6'd0);
        check("rst_rdata_valid", rdata_valid, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        // Non-memory opcode and deasserted req_valid are both ignored.
        cur_vec = 100;
        req_valid = 1'b1; opcode = 6'h00; addr = 32'h0000_0100;
        @(negedge clk);
        check("nonmem_stall", stall, 1'b0);
        check("nonmem_misalign", misalign_err, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0; opcode = SW;
        @(negedge clk);
        check("nonmem_req", mif.mem_req, 1'b0);
        check("novalid_stall", stall, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("novalid_req", mif.mem_req, 1'b0);
        @(posedge clk); #1;

        // Timeout: no ack for four WAIT cycles, then abort with bus_err.
        cur_vec = 101;
        req_valid = 1'b1; opcode = LW; addr = 32'h0000_0300;
        @(negedge clk);
        check("to_issue_stall", stall, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("to_wait_req", mif.mem_req, 1'b1);
            check("to_wait_stall", stall, 1'b1);
            check("to_wait_bus_err", bus_err, 1'b0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        mif.mem_ack = 1'b1;
        @(negedge clk);
        check("to_bus_err", bus_err, 1'b1);
        check("to_req_drop", mif.mem_req, 1'b0);
        check("to_stall_drop", stall, 1'b0);
        check("to_rdata_valid", rdata_valid, 1'b0);
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        check("to_bus_err_pulse", bus_err, 1'b0);
        check("stray_ack_rdata_valid", rdata_valid, 1'b0);
        check("stray_ack_rdata_out", rdata_out, last_rdata);
        @(posedge clk); #1;

        // Asynchronous reset in WAIT drops mem_req before any clock edge.
        cur_vec = 102;
        req_valid = 1'b1; opcode = LW; addr = 32'h0000_0400;
        @(negedge clk);
        check("ar_issue_stall", stall, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("ar_wait_req", mif.mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req_async", mif.mem_req, 1'b0);
        check("ar_stall", stall, 1'b0);
        check("ar_rdata_out", rdata_out, 32'd0);
        last_rdata = 32'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cur_vec = 103;
        run_vec(mk(LW, 32'h0000_0404, 32'h0, 32'h55AA_33CC, 2, 1'b0, 4'b0000, 30'h101, 32'h0, 1'b1, 2'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
